ethernet_system_button_pio: RTL and testbench
=============================================

// Module: ethernet_system_button_pio
// PURPOSE
//  Avalon-MM slave input PIO: samples external push-buttons, captures edges, raises a level IRQ to the Nios CPU.
//  Read-side counterpart of the LED output PIO; sits on the same system interconnect.
//  Provides a 2-flop synchroniser, an optional debouncer, edge-capture and interrupt-mask registers.
// PARAMETERS
//  WIDTH        4      number of input bits (1..32)
//  EDGE_TYPE    2      capture edge: 0 = rising, 1 = falling, 2 = any
//  DEBOUNCE_CYC 16     stable cycles required before the debounced value changes (>=2; used only with macro)
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous active-low reset
//  address      in   2      register select
//  chipselect   in   1      slave select
//  write_n      in   1      active-low write strobe
//  writedata    in   32     write data; bits [WIDTH-1:0] used
//  in_port      in   WIDTH  raw asynchronous button inputs
//  readdata     out  32     registered read data, zero-extended
//  irq          out  1      level interrupt, active high
// BEHAVIOUR
//  Reset: clk is the clock; reset_n is the asynchronous, active-low reset. All flops clear:
//   sync stages, debounced value, edge_capture, irq_mask, readdata, irq = 0.
//  Register map (word addresses):
//   0 DATA   RO  current filtered input value
//   1 -      RO  reads 0; writes ignored
//   2 MASK   RW  irq_mask[WIDTH-1:0]
//   3 EDGE   R/W1C  edge_capture; writing 1 to bit n clears bit n
//  Write: takes effect when chipselect && !write_n, on the next rising clk.
//  Read: readdata <= mux(address) every clk, unconditionally; read latency 1 cycle, no wait states.
//   Bits [31:WIDTH] always 0.
//  Input path: in_port -> sync1 -> sync2 (2 flops) -> filter -> val; prev <= val every cycle.
//   Filtered input latency: 2 cycles without debounce; 2+DEBOUNCE_CYC cycles with debounce.
//  Edge detect per bit: rise = val & ~prev; fall = ~val & prev; EDGE_TYPE selects rise, fall or rise|fall.
//  edge_capture[n] <= (edge_capture[n] & ~clr[n]) | det[n].
//   Detect-and-clear in the same cycle: set wins, so an edge is never lost.
//  irq <= |(edge_capture & irq_mask), registered; asserts 1 cycle after capture; deasserts 1 cycle after clear/mask.
//  MASK write does not alter edge_capture; unmasking a pending bit asserts irq on the next cycle.
//  Reset mid-operation: pending edges are discarded; the first sample after reset produces no edge (prev = val = 0 path).
//  An input held high through reset produces a rise edge once it propagates (rising/any modes).
// CONFIGURATION
//  BUTTON_PIO_DEBOUNCE_EN defined: each bit passes through a debouncer. A per-bit counter resets on any sync2 change;
//   when the counter reaches DEBOUNCE_CYC-1, val takes sync2. Glitches shorter than DEBOUNCE_CYC cycles produce no edge.
//  Not defined: val = sync2 directly; no counters are instantiated; DEBOUNCE_CYC is ignored.
// STRUCTURE
//  Shared package ethernet_system_pio_pkg: register address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3),
//   EDGE_RISE/EDGE_FALL/EDGE_ANY codes. These are reused by the LED PIO and future PIOs.
//  Sub-module button_pio_debounce: one bit, parameter DEBOUNCE_CYC, ports clk/reset_n/din/dout.
//   Generated WIDTH times under the macro.
//  Top level holds the synchronisers, edge logic, registers, read mux and irq flop.
// TESTING
//  1 Reset with in_port=4'hF held; release reset, wait 4 cycles, read addr0 -> 32'h0000000F;
//    with EDGE_TYPE=0, read addr3 -> 32'h0000000F.
//  2 Write MASK=4'h1; pulse in_port[0] 0->1 (no macro) -> edge_capture=4'h1 and irq=1 within 4 cycles;
//    write EDGE=4'h1 -> irq=0 one cycle after capture clears.
//  3 Edge on bit 2 and W1C of bit 2 in the same cycle -> edge_capture[2] stays 1.
//  4 EDGE_TYPE=1: a 0->1 transition does not capture; the following 1->0 transition sets the bit.
//    EDGE_TYPE=2: both transitions set the bit.
//  5 With BUTTON_PIO_DEBOUNCE_EN, DEBOUNCE_CYC=16: a 10-cycle glitch on bit 1 -> no capture, DATA unchanged;
//    a 20-cycle level on bit 1 -> DATA bit1=1 after 18 cycles and capture set.
//  6 Assert reset_n low mid-operation with edge_capture=4'hA, mask=4'hF, irq=1 -> all cleared immediately;
//    reads of addr1 -> 0.

Source files
------------

// File: rtl/ethernet_system_pio_pkg.sv
// Shared definitions for the ethernet_system parallel-I/O slaves (button and LED PIOs).
// Holds the Avalon word-address map and the edge-capture mode codes.
package ethernet_system_pio_pkg;

  // Word addresses of the PIO register file
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge-capture mode codes
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Per-bit edge detector: cur is this cycle's filtered input, last is the previous cycle's
  function automatic logic [31:0] edge_select(input logic [31:0] cur,
                                              input logic [31:0] last,
                                              input int          edge_type);
    logic [31:0] rise;
    logic [31:0] fall;
    rise = cur & ~last;
    fall = ~cur & last;
    case (edge_type)
      EDGE_RISE: edge_select = rise;
      EDGE_FALL: edge_select = fall;
      default:   edge_select = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/button_pio_debounce.sv
// Single-bit debouncer for the button PIO.
// The output follows the input only after the input has held one value for
// DEBOUNCE_CYC consecutive samples; any change restarts the count.
module button_pio_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int            CW      = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          din_last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          stable;

  // Count consecutive equal samples, saturating at CNT_MAX; a change restarts from zero
  always_comb begin
    stable   = (din == din_last);
    cnt_next = '0;
    if (stable) begin
      if (cnt == CNT_MAX) cnt_next = cnt;
      else                cnt_next = cnt + CW'(1);
    end
  end

  // Stability counter, last-sample register and the debounced output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_last <= 1'b0;
      cnt      <= '0;
      dout     <= 1'b0;
    end else begin
      din_last <= din;
      cnt      <= cnt_next;
      if (stable && (cnt_next == CNT_MAX)) dout <= din;
    end
  end

endmodule

// File: rtl/ethernet_system_button_pio.sv
// Avalon-MM input PIO for the push-buttons: synchronises the raw inputs,
// optionally debounces them, captures edges and raises a level IRQ.
// Optional feature macro: BUTTON_PIO_DEBOUNCE_EN (adds a per-bit debouncer).
//
// Bus handshake: zero-wait-state slave with no waitrequest. A write is
// accepted on the rising clk edge where chipselect && !write_n. readdata is
// refreshed from the addressed register on every edge, so read data is valid
// exactly one cycle after the address is presented.
module ethernet_system_button_pio
  import ethernet_system_pio_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int EDGE_TYPE    = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [31:0]      det_all;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_bits;

  assign wr_en = chipselect & ~write_n;

  // Upper writedata bits and upper detector bits carry nothing for narrow ports
  assign unused_bits = &{1'b0, writedata, det_all};

  // Two-flop synchroniser on the asynchronous button inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    button_pio_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sync2[i]),
      .dout   (val[i])
    );
  end
`else
  assign val = sync2;
`endif

  // Previous filtered value for edge detection; zero after reset so no spurious edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= val;
  end

  // Edge detection and write-one-to-clear mask for the capture register
  always_comb begin
    det_all = edge_select(32'(val), 32'(prev), EDGE_TYPE);
    det     = det_all[WIDTH-1:0];
    clr     = '0;
    if (wr_en && (address == ADDR_EDGE)) clr = writedata[WIDTH-1:0];
  end

  // Edge capture: a new edge wins over a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~clr) | det;
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               irq_mask <= '0;
    else if (wr_en && (address == ADDR_MASK))   irq_mask <= writedata[WIDTH-1:0];
  end

  // Read multiplexer, zero-extended to the bus width
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = val;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // Registered read data and level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_ethernet_system_button_pio.sv
// Bench for ethernet_system_button_pio: three instances (rising, falling, any
// edge) share one bus and one input vector. A history-based reference model
// predicts readdata/irq every cycle; directed tables and sequences add
// constant-valued checks for the corner cases.
`timescale 1ns/1ps
module tb_ethernet_system_button_pio;
  import ethernet_system_pio_pkg::*;

  localparam int W  = 4;
  localparam int DB = 16;
  localparam int NI = 3;
  localparam int HN = DB + 4;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int FLT = DB;
`else
  localparam int FLT = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [1:0]            address = 2'd0;
  logic                  chipselect = 1'b0;
  logic                  write_n = 1'b1;
  logic [31:0]           writedata = 32'd0;
  logic [W-1:0]          in_port = '0;
  logic [NI-1:0][31:0]   rd;
  logic [NI-1:0]         irq_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ethernet_system_button_pio #(
      .WIDTH(W), .EDGE_TYPE(g), .DEBOUNCE_CYC(DB)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[g]), .irq(irq_o[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // raw[0] is the most recent input sample; filt_m/prev_m are the filtered
  // input before/one cycle before the current edge.
  logic [W-1:0] raw [HN];
  logic [W-1:0] filt_m = '0, prev_m = '0, mask_m = '0;
  logic [W-1:0] ec_m [NI];
  logic [31:0]  exp_rd [NI];
  logic         exp_irq [NI];
  logic [W-1:0] m_f, m_p, m_rise, m_fall, m_det, m_clr;
  logic         m_same;

  initial begin
    for (int k = 0; k < HN; k++) raw[k] = '0;
    for (int i = 0; i < NI; i++) begin ec_m[i] = '0; exp_rd[i] = '0; exp_irq[i] = 1'b0; end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < HN; k++) raw[k] = '0;
      filt_m = '0; prev_m = '0; mask_m = '0;
      for (int i = 0; i < NI; i++) begin ec_m[i] = '0; exp_rd[i] = '0; exp_irq[i] = 1'b0; end
    end else begin
      m_f    = filt_m;
      m_p    = prev_m;
      m_rise = m_f & ~m_p;
      m_fall = ~m_f & m_p;
      m_clr  = (chipselect && !write_n && address == ADDR_EDGE) ? writedata[W-1:0] : '0;
      for (int i = 0; i < NI; i++) begin
        case (address)
          ADDR_DATA: exp_rd[i] = 32'(m_f);
          ADDR_MASK: exp_rd[i] = 32'(mask_m);
          ADDR_EDGE: exp_rd[i] = 32'(ec_m[i]);
          default:   exp_rd[i] = 32'd0;
        endcase
        exp_irq[i] = |(ec_m[i] & mask_m);
        m_det = (i == 0) ? m_rise : (i == 1) ? m_fall : (m_rise | m_fall);
        ec_m[i] = (ec_m[i] & ~m_clr) | m_det;
      end
      if (chipselect && !write_n && address == ADDR_MASK) mask_m = writedata[W-1:0];
      prev_m = m_f;
`ifdef BUTTON_PIO_DEBOUNCE_EN
      for (int b = 0; b < W; b++) begin
        m_same = 1'b1;
        for (int k = 2; k <= DB; k++) if (raw[k][b] != raw[1][b]) m_same = 1'b0;
        if (m_same) filt_m[b] = raw[1][b];
      end
`else
      filt_m = raw[0];
`endif
      for (int k = HN - 1; k > 0; k--) raw[k] = raw[k-1];
      raw[0] = in_port;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("model_rd[%0d]", i), rd[i], exp_rd[i]);
      chk($sformatf("model_irq[%0d]", i), 32'(irq_o[i]), 32'(exp_irq[i]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [NI-1:0][31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = rd;
    chipselect = 1'b0;
  endtask

  task automatic chk_all(input string name, input logic [NI-1:0][31:0] d,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    chk({name, "_rise"}, d[0], e0);
    chk({name, "_fall"}, d[1], e1);
    chk({name, "_any"},  d[2], e2);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] in_v;
    logic [W-1:0] e_rise;
    logic [W-1:0] e_fall;
    logic [W-1:0] e_any;
  } vec_t;

  vec_t tbl [6];
  logic [NI-1:0][31:0] d;
  int waited;

  initial begin
    // Edge table, each row relative to the previous input value (starts from 4'hF)
    tbl[0] = '{4'h0, 4'h0, 4'hF, 4'hF};
    tbl[1] = '{4'h5, 4'h5, 4'h0, 4'h5};
    tbl[2] = '{4'hA, 4'hA, 4'h5, 4'hF};
    tbl[3] = '{4'hA, 4'h0, 4'h0, 4'h0};
    tbl[4] = '{4'h3, 4'h1, 4'h8, 4'h9};
    tbl[5] = '{4'h0, 4'h0, 4'h3, 4'h3};

    // Reset with all buttons held; they propagate as rise edges
    in_port = 4'hF;
    reset_n = 1'b0;
    tick(3);
    chk_all("reset_rd", rd, 32'h0, 32'h0, 32'h0);
    chk("reset_irq", 32'(irq_o), 32'h0);
    reset_n = 1'b1;
    tick(4 + FLT);
    bus_read(ADDR_DATA, d);
    chk_all("held_data", d, 32'hF, 32'hF, 32'hF);
    bus_read(ADDR_EDGE, d);
    chk_all("held_edge", d, 32'hF, 32'h0, 32'hF);
    bus_write(ADDR_EDGE, 32'hF);

    // Table-driven edge modes
    for (int k = 0; k < 6; k++) begin
      in_port = tbl[k].in_v;
      tick(3 + FLT);
      bus_read(ADDR_DATA, d);
      chk_all($sformatf("tbl%0d_data", k), d, 32'(tbl[k].in_v), 32'(tbl[k].in_v), 32'(tbl[k].in_v));
      bus_read(ADDR_EDGE, d);
      chk_all($sformatf("tbl%0d_edge", k), d, 32'(tbl[k].e_rise), 32'(tbl[k].e_fall), 32'(tbl[k].e_any));
      bus_write(ADDR_EDGE, 32'hF);
    end

    // IRQ assert on masked capture, deassert after W1C
    bus_write(ADDR_MASK, 32'h1);
    bus_read(ADDR_MASK, d);
    chk_all("mask_rb", d, 32'h1, 32'h1, 32'h1);
    in_port = 4'h1;
    waited = 0;
    while (!irq_o[0] && waited < 6 + FLT) begin
      tick(1);
      waited++;
    end
    chk("irq_wait_rise", 32'(irq_o[0]), 32'h1);
    chk("irq_wait_fall", 32'(irq_o[1]), 32'h0);
    bus_read(ADDR_EDGE, d);
    chk_all("irq_edge", d, 32'h1, 32'h0, 32'h1);
    bus_write(ADDR_EDGE, 32'h1);
    chk("irq_hold_after_clr", 32'(irq_o[0]), 32'h1);
    tick(1);
    chk("irq_drop_after_clr", 32'(irq_o[0]), 32'h0);
    in_port = 4'h0;
    tick(4 + FLT);
    bus_write(ADDR_EDGE, 32'hF);
    bus_write(ADDR_MASK, 32'h0);

    // Edge on bit 2 and W1C of bit 2 on the same clock edge: the edge survives
    in_port = 4'h4;
    tick(1 + FLT);
    bus_write(ADDR_EDGE, 32'h4);
    bus_read(ADDR_EDGE, d);
    chk_all("set_wins", d, 32'h4, 32'h0, 32'h4);
    in_port = 4'h0;
    tick(4 + FLT);
    bus_write(ADDR_EDGE, 32'hF);

    // Reserved address reads zero and ignores writes
    bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
    bus_read(ADDR_RSVD, d);
    chk_all("rsvd", d, 32'h0, 32'h0, 32'h0);

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // Short glitch is filtered; a long level passes after 2+DB cycles
    in_port = 4'h2;
    tick(10);
    in_port = 4'h0;
    tick(DB + 6);
    bus_read(ADDR_DATA, d);
    chk_all("glitch_data", d, 32'h0, 32'h0, 32'h0);
    bus_read(ADDR_EDGE, d);
    chk_all("glitch_edge", d, 32'h0, 32'h0, 32'h0);
    in_port = 4'h2;
    tick(2 + DB);
    bus_read(ADDR_DATA, d);
    chk_all("level_data", d, 32'h2, 32'h2, 32'h2);
    bus_read(ADDR_EDGE, d);
    chk_all("level_edge", d, 32'h2, 32'h0, 32'h2);
    in_port = 4'h0;
    tick(4 + FLT);
    bus_write(ADDR_EDGE, 32'hF);
`endif

    // Reset in the middle of operation with pending, unmasked edges
    bus_write(ADDR_MASK, 32'hF);
    in_port = 4'hA;
    tick(4 + FLT);
    chk("pre_rst_irq_rise", 32'(irq_o[0]), 32'h1);
    chk("pre_rst_irq_any",  32'(irq_o[2]), 32'h1);
    bus_read(ADDR_EDGE, d);
    chk_all("pre_rst_edge", d, 32'hA, 32'h0, 32'hA);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_irq", 32'(irq_o), 32'h0);
    chk_all("rst_async_rd", rd, 32'h0, 32'h0, 32'h0);
    tick(2);
    reset_n = 1'b1;
    bus_read(ADDR_EDGE, d);
    chk_all("post_rst_edge", d, 32'h0, 32'h0, 32'h0);
    bus_read(ADDR_RSVD, d);
    chk_all("post_rst_rsvd", d, 32'h0, 32'h0, 32'h0);
    bus_read(ADDR_MASK, d);
    chk_all("post_rst_mask", d, 32'h0, 32'h0, 32'h0);
    tick(4 + FLT);
    bus_read(ADDR_EDGE, d);
    chk_all("post_rst_rise", d, 32'hA, 32'h0, 32'hA);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
